vga_timing_generator: RTL and testbench



---
 rtl/vga_pkg.sv | 23 ++
 rtl/wrap_counter.sv | 43 ++++
 rtl/vga_timing_generator.sv | 91 +++++++++
 tb/tb_vga_timing_generator.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480@60 Hz mode.
// Holds the default visible size, porches and sync widths, the derived line and frame
// totals, and the sync pulse polarity. No ports.
package vga_pkg;

    localparam int unsigned DEF_WIDTH         = 640;
    localparam int unsigned DEF_HEIGHT        = 480;
    localparam int unsigned DEF_H_FRONT_PORCH = 16;
    localparam int unsigned DEF_H_SYNC_WIDTH  = 96;
    localparam int unsigned DEF_H_BACK_PORCH  = 48;
    localparam int unsigned DEF_V_FRONT_PORCH = 10;
    localparam int unsigned DEF_V_SYNC_WIDTH  = 2;
    localparam int unsigned DEF_V_BACK_PORCH  = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_WIDTH + DEF_H_FRONT_PORCH + DEF_H_SYNC_WIDTH + DEF_H_BACK_PORCH;
    localparam int unsigned DEF_V_TOTAL =
        DEF_HEIGHT + DEF_V_FRONT_PORCH + DEF_V_SYNC_WIDTH + DEF_V_BACK_PORCH;

    // Level driven on hSync/vSync during the pulse.
    localparam logic SYNC_ACTIVE = 1'b0;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-N counter with enable.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous active-high reset, clears the count
//   en_i     - advance the count this cycle
//   count_o  - current count, 0..N-1
//   wrap_o   - high when enabled and the count is at N-1 (count returns to 0 next edge)
module wrap_counter #(
    parameter int unsigned N     = 800,
    parameter int unsigned Width = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] Last = Width'(N - 1);

    logic [Width-1:0] count_d, count_q;
    logic             at_last;

    always_comb begin
        at_last = (count_q == Last);
        count_d = count_q;
        if (en_i) begin
            count_d = at_last ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign wrap_o  = en_i && at_last;

endmodule

// File: rtl/vga_timing_generator.sv
// VGA timing generator: pixel/line counters plus combinational decode of sync pulses,
// active-video flag, frame-boundary strobe and clamped pixel coordinates.
// Ports:
//   clk25     - pixel clock, rising edge
//   reset     - synchronous active-high reset, restarts the frame at (0,0)
//   hSync     - horizontal sync, active low
//   vSync     - vertical sync, active low
//   active    - current pixel is inside the visible area
//   screenEnd - one-cycle strobe at the first pixel of vertical blanking
//   x         - current column, held at WIDTH-1 outside the visible columns
//   y         - current row, held at HEIGHT-1 outside the visible rows
module vga_timing_generator
    import vga_pkg::*;
#(
    parameter int unsigned WIDTH         = DEF_WIDTH,
    parameter int unsigned HEIGHT        = DEF_HEIGHT,
    parameter int unsigned H_FRONT_PORCH = DEF_H_FRONT_PORCH,
    parameter int unsigned H_SYNC_WIDTH  = DEF_H_SYNC_WIDTH,
    parameter int unsigned H_BACK_PORCH  = DEF_H_BACK_PORCH,
    parameter int unsigned V_FRONT_PORCH = DEF_V_FRONT_PORCH,
    parameter int unsigned V_SYNC_WIDTH  = DEF_V_SYNC_WIDTH,
    parameter int unsigned V_BACK_PORCH  = DEF_V_BACK_PORCH
) (
    input  logic       clk25,
    input  logic       reset,
    output logic       hSync,
    output logic       vSync,
    output logic       active,
    output logic       screenEnd,
    output logic [9:0] x,
    output logic [8:0] y
);

    localparam int unsigned H_TOTAL = WIDTH + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int unsigned V_TOTAL = HEIGHT + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam int unsigned H_SYNC_START = WIDTH + H_FRONT_PORCH;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_WIDTH;
    localparam int unsigned V_SYNC_START = HEIGHT + V_FRONT_PORCH;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_WIDTH;

    logic [9:0]  h_count, v_count;
    logic        h_wrap, v_wrap;
    logic        unused_v_wrap;
    logic [31:0] h_ext, v_ext;
    logic        h_vis, v_vis, h_pulse, v_pulse;

    wrap_counter #(
        .N    (H_TOTAL),
        .Width(10)
    ) u_h_counter (
        .clk_i  (clk25),
        .rst_i  (reset),
        .en_i   (1'b1),
        .count_o(h_count),
        .wrap_o (h_wrap)
    );

    // The line counter only advances on the last pixel of each line.
    wrap_counter #(
        .N    (V_TOTAL),
        .Width(10)
    ) u_v_counter (
        .clk_i  (clk25),
        .rst_i  (reset),
        .en_i   (h_wrap),
        .count_o(v_count),
        .wrap_o (v_wrap)
    );

    assign unused_v_wrap = v_wrap;

    always_comb begin
        // Compare at 32 bits so limit values that do not fit the counters still decode.
        h_ext   = 32'(h_count);
        v_ext   = 32'(v_count);
        h_vis   = (h_ext < WIDTH);
        v_vis   = (v_ext < HEIGHT);
        h_pulse = (h_ext >= H_SYNC_START) && (h_ext < H_SYNC_END);
        v_pulse = (v_ext >= V_SYNC_START) && (v_ext < V_SYNC_END);

        hSync     = h_pulse ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vSync     = v_pulse ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        active    = h_vis && v_vis;
        screenEnd = (h_count == '0) && (v_ext == HEIGHT);
        // Clamp so x + WIDTH*y stays inside the frame buffer during blanking.
        x         = h_vis ? h_count : 10'(WIDTH - 1);
        y         = v_vis ? v_count[8:0] : 9'(HEIGHT - 1);
    end

endmodule

// File: tb/tb_vga_timing_generator.sv
module tb_vga_timing_generator;

    // Reduced timing for frame-level checks (frame = 32*19 = 608 cycles).
    localparam int SW = 20, SH = 12, SHFP = 3, SHSW = 4, SHBP = 5;
    localparam int SVFP = 2, SVSW = 2, SVBP = 3;
    localparam int SHT = SW + SHFP + SHSW + SHBP;
    localparam int SVT = SH + SVFP + SVSW + SVBP;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       act;
        logic       se;
        logic [9:0] x;
        logic [8:0] y;
    } out_t;

    typedef struct {
        int   cyc;
        out_t exp;
    } vec_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst_d, rst_s;
    logic       d_hs, d_vs, d_act, d_se, s_hs, s_vs, s_act, s_se;
    logic [9:0] d_x, s_x;
    logic [8:0] d_y, s_y;

    vga_timing_generator u_dut (
        .clk25(clk), .reset(rst_d), .hSync(d_hs), .vSync(d_vs), .active(d_act),
        .screenEnd(d_se), .x(d_x), .y(d_y)
    );

    vga_timing_generator #(
        .WIDTH(SW), .HEIGHT(SH), .H_FRONT_PORCH(SHFP), .H_SYNC_WIDTH(SHSW),
        .H_BACK_PORCH(SHBP), .V_FRONT_PORCH(SVFP), .V_SYNC_WIDTH(SVSW), .V_BACK_PORCH(SVBP)
    ) u_dut_s (
        .clk25(clk), .reset(rst_s), .hSync(s_hs), .vSync(s_vs), .active(s_act),
        .screenEnd(s_se), .x(s_x), .y(s_y)
    );

    int   checks = 0;
    int   errors = 0;
    int   hd, vd, hs_m, vs_m;
    bit   valid_d = 0, valid_s = 0;
    out_t q_d[$];
    out_t q_s[$];

    function automatic out_t model(int hc, int vc, int w, int h, int hfp, int hsw,
                                   int vfp, int vsw);
        out_t o;
        o.hs  = !(hc >= w + hfp && hc < w + hfp + hsw);
        o.vs  = !(vc >= h + vfp && vc < h + vfp + vsw);
        o.act = (hc < w) && (vc < h);
        o.se  = (hc == 0) && (vc == h);
        o.x   = (hc < w) ? 10'(hc) : 10'(w - 1);
        o.y   = (vc < h) ? 9'(vc) : 9'(h - 1);
        return o;
    endfunction

    task automatic check(string name, int cyc, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // One clock: advance the reference counters, push expectations, compare after the edge.
    task automatic step();
        out_t e, g;
        @(posedge clk);
        if (rst_d) begin
            hd = 0; vd = 0; valid_d = 1;
        end else begin
            hd++;
            if (hd == 800) begin
                hd = 0; vd++;
                if (vd == 525) vd = 0;
            end
        end
        if (rst_s) begin
            hs_m = 0; vs_m = 0; valid_s = 1;
        end else begin
            hs_m++;
            if (hs_m == SHT) begin
                hs_m = 0; vs_m++;
                if (vs_m == SVT) vs_m = 0;
            end
        end
        if (valid_d) q_d.push_back(model(hd, vd, 640, 480, 16, 96, 10, 2));
        if (valid_s) q_s.push_back(model(hs_m, vs_m, SW, SH, SHFP, SHSW, SVFP, SVSW));
        #1;
        if (q_d.size() > 0) begin
            e = q_d.pop_front();
            g = {d_hs, d_vs, d_act, d_se, d_x, d_y};
            check("sb_default", vd * 800 + hd, 32'(g), 32'(e));
        end
        if (q_s.size() > 0) begin
            e = q_s.pop_front();
            g = {s_hs, s_vs, s_act, s_se, s_x, s_y};
            check("sb_small", vs_m * SHT + hs_m, 32'(g), 32'(e));
        end
    endtask

    vec_t vecs[$];
    int   first_se, n_se, last_se, gap, hs_low, vs_low;

    initial begin
        // Cycles after reset release on the default-timing instance: {hs,vs,act,se,x,y}.
        vecs.push_back('{0,    '{1'b1, 1'b1, 1'b1, 1'b0, 10'd0,   9'd0}});
        vecs.push_back('{1,    '{1'b1, 1'b1, 1'b1, 1'b0, 10'd1,   9'd0}});
        vecs.push_back('{639,  '{1'b1, 1'b1, 1'b1, 1'b0, 10'd639, 9'd0}});
        vecs.push_back('{640,  '{1'b1, 1'b1, 1'b0, 1'b0, 10'd639, 9'd0}});
        vecs.push_back('{655,  '{1'b1, 1'b1, 1'b0, 1'b0, 10'd639, 9'd0}});
        vecs.push_back('{656,  '{1'b0, 1'b1, 1'b0, 1'b0, 10'd639, 9'd0}});
        vecs.push_back('{751,  '{1'b0, 1'b1, 1'b0, 1'b0, 10'd639, 9'd0}});
        vecs.push_back('{752,  '{1'b1, 1'b1, 1'b0, 1'b0, 10'd639, 9'd0}});
        vecs.push_back('{799,  '{1'b1, 1'b1, 1'b0, 1'b0, 10'd639, 9'd0}});
        vecs.push_back('{800,  '{1'b1, 1'b1, 1'b1, 1'b0, 10'd0,   9'd1}});
        vecs.push_back('{1456, '{1'b0, 1'b1, 1'b0, 1'b0, 10'd639, 9'd1}});
        vecs.push_back('{1600, '{1'b1, 1'b1, 1'b1, 1'b0, 10'd0,   9'd2}});

        rst_d = 1'b1;
        rst_s = 1'b1;
        step();
        step();
        rst_d = 1'b0;
        rst_s = 1'b0;

        // Default timing: first lines, hSync placement, line advance.
        hs_low = 0;
        begin
            int vi = 0;
            for (int c = 0; c <= 1700; c++) begin
                if (vi < vecs.size() && vecs[vi].cyc == c) begin
                    check("vec", c, 32'(out_t'({d_hs, d_vs, d_act, d_se, d_x, d_y})),
                          32'(vecs[vi].exp));
                    vi++;
                end
                if (c < 800 && !d_hs) hs_low++;
                step();
            end
            check("vec_all_applied", 0, 32'(vi), 32'(vecs.size()));
        end
        check("hsync_low_cycles", 0, 32'(hs_low), 32'd96);

        // Reduced timing: frame-level behaviour from a fresh reset.
        rst_s = 1'b1;
        step();
        step();
        rst_s = 1'b0;
        first_se = -1; n_se = 0; last_se = -1; gap = -1; vs_low = 0;
        for (int c = 0; c < 3 * 608; c++) begin
            if (s_se) begin
                if (first_se < 0) first_se = c;
                else if (gap < 0) gap = c - last_se;
                last_se = c;
                n_se++;
            end
            if (c < 608 && !s_vs) vs_low++;
            if (c == 607) check("s_last_pixel_x", c, 32'(s_x), 32'(SW - 1));
            if (c == 608) begin
                check("s_wrap_x", c, 32'(s_x), 32'd0);
                check("s_wrap_y", c, 32'(s_y), 32'd0);
                check("s_wrap_active", c, 32'(s_act), 32'd1);
            end
            step();
        end
        check("s_first_se", 0, 32'(first_se), 32'(SH * SHT));
        check("s_se_spacing", 0, 32'(gap), 32'd608);
        check("s_se_count", 0, 32'(n_se), 32'd3);
        check("s_vsync_low_cycles", 0, 32'(vs_low), 32'(SVSW * SHT));

        // Mid-frame reset at line 7, pixel 10 for one cycle.
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        for (int c = 0; c < 7 * SHT + 10; c++) step();
        check("s_pre_reset_x", 0, 32'(s_x), 32'd10);
        check("s_pre_reset_y", 0, 32'(s_y), 32'd7);
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        check("s_mid_reset_x", 0, 32'(s_x), 32'd0);
        check("s_mid_reset_y", 0, 32'(s_y), 32'd0);
        first_se = -1; n_se = 0;
        for (int c = 0; c <= SH * SHT + 10; c++) begin
            if (s_se) begin
                if (first_se < 0) first_se = c;
                n_se++;
            end
            step();
        end
        check("s_mid_reset_first_se", 0, 32'(first_se), 32'(SH * SHT));
        check("s_mid_reset_se_count", 0, 32'(n_se), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
